// File: rtl/cdc_pkg.sv
// Shared definitions for the clk_b-domain capture path: pointer sizing helper,
// saturation pattern and the default data width.
package cdc_pkg;

  localparam int unsigned DW_DEF = 8;

  // All-ones pattern; truncated to the counter width at the point of use.
  localparam logic [31:0] CNT_SAT = '1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $unsigned($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and
// registered valid/full/level status.
module sync_fifo
  import cdc_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [DW-1:0]             wdata_i,
  input  logic                      pop_i,
  output logic [DW-1:0]             rdata_c_o,
  output logic                      valid_o,
  output logic                      full_o,
  output logic [ptr_w(DEPTH)-1:0]   level_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          pop_en, push_en;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop_en  = pop_i && valid_q;
    push_en = push_i && (!full_q || pop_en);
    wr_d    = wr_q + PW'(push_en);
    rd_d    = rd_q + PW'(pop_en);
    level_d = wr_d - rd_d;
    valid_d = (wr_d != rd_d);
    full_d  = ((wr_d ^ rd_d) == {1'b1, AW'(0)});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      if (push_en) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
      end
    end
  end

  assign rdata_c_o = mem_q[rd_q[AW-1:0]];
  assign valid_o   = valid_q;
  assign full_o    = full_q;
  assign level_o   = level_q;

endmodule

// File: rtl/pulse_data_capture.sv
// Samples the source bus on each enabled sync pulse into a FWFT FIFO, returns a
// toggle acknowledge and counts words lost to a full FIFO.
module pulse_data_capture
  import cdc_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                      clk_b,
  input  logic                      rst_b,
  input  logic                      sync_pulse,
  input  logic [DW-1:0]             data_in,
  input  logic                      cap_en,
  input  logic                      drop_clr,
  output logic                      out_valid,
  output logic [DW-1:0]             out_data,
  input  logic                      out_ready,
  output logic [ptr_w(DEPTH)-1:0]   fifo_level,
  output logic                      ack_tgl,
  output logic [CW-1:0]             drop_cnt,
  output logic                      overflow
);

  logic          cap_c, pop_c, drop_c, full;
  logic          ack_q, ack_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          ovf_q, ovf_d;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_b),
    .rst_i     (rst_b),
    .push_i    (cap_c),
    .wdata_i   (data_in),
    .pop_i     (out_ready),
    .rdata_c_o (out_data),
    .valid_o   (out_valid),
    .full_o    (full),
    .level_o   (fifo_level)
  );

  // Ack toggles on every enabled pulse, even a dropped one, so the source never stalls.
  always_comb begin
    cap_c      = sync_pulse && cap_en;
    pop_c      = out_valid && out_ready;
    drop_c     = cap_c && full && !pop_c;
    ack_d      = ack_q ^ cap_c;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (drop_c) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != CW'(CNT_SAT)) begin
        drop_cnt_d = drop_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      ack_q      <= 1'b0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ack_tgl  = ack_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_data_capture.sv
// Scoreboard bench for pulse_data_capture: queue-based reference model, negedge
// monitor, directed scenarios followed by randomized traffic.
module tb_pulse_data_capture;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 2;
  localparam int          SAT   = 3;

  logic          clk_b = 1'b0;
  logic          rst_b, sync_pulse, cap_en, drop_clr, out_ready;
  logic [DW-1:0] data_in;
  logic          out_valid, ack_tgl, overflow;
  logic [DW-1:0] out_data;
  logic [2:0]    fifo_level;
  logic [CW-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_ack;
  int         m_dc;
  bit         m_ov;

  always #5 clk_b = ~clk_b;

  pulse_data_capture #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk_b      (clk_b),
    .rst_b      (rst_b),
    .sync_pulse (sync_pulse),
    .data_in    (data_in),
    .cap_en     (cap_en),
    .drop_clr   (drop_clr),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .ack_tgl    (ack_tgl),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: a queue of words plus ack parity, drop tally and sticky flag.
  always @(posedge clk_b) begin
    bit popped;
    if (rst_b) begin
      mq.delete();
      exp_q.delete();
      m_ack = 1'b0;
      m_dc  = 0;
      m_ov  = 1'b0;
    end else begin
      popped = (mq.size() > 0) && out_ready;
      if (popped) void'(mq.pop_front());
      if (sync_pulse && cap_en) begin
        m_ack = ~m_ack;
        if (mq.size() < DEPTH) begin
          mq.push_back(data_in);
          exp_q.push_back(data_in);
        end else if (!drop_clr) begin
          m_dc = (m_dc < SAT) ? m_dc + 1 : SAT;
          m_ov = 1'b1;
        end
      end
      if (drop_clr) begin
        m_dc = 0;
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: status against the model each cycle, head word against the scoreboard.
  always @(negedge clk_b) begin
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("ack_tgl", int'(ack_tgl), int'(m_ack));
    chk("drop_cnt", int'(drop_cnt), m_dc);
    chk("overflow", int'(overflow), int'(m_ov));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("head_present", 1, 0);
      end else begin
        chk("head_data", int'(out_data), int'(exp_q[0]));
        if (out_ready && !rst_b) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit p, input logic [7:0] d, input bit en,
                      input bit rdy, input bit clr, input bit rst);
    sync_pulse = p;
    data_in    = d;
    cap_en     = en;
    out_ready  = rdy;
    drop_clr   = clr;
    rst_b      = rst;
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_ack"}, int'(ack_tgl), 0);
    chk({tag, "_drop"}, int'(drop_cnt), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    step(0, 8'h00, 1, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_reset_state("rst");

    // Single capture: visible one cycle later.
    step(1, 8'hA5, 1, 0, 0, 0);
    chk("a5_valid", int'(out_valid), 1);
    chk("a5_data", int'(out_data), 8'hA5);
    chk("a5_level", int'(fifo_level), 1);
    chk("a5_ack", int'(ack_tgl), 1);
    step(0, 8'h00, 1, 1, 0, 0);
    chk("a5_popped", int'(out_valid), 0);

    // Fill with 1..4, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 1, 0, 0, 0);
    chk("fill_level", int'(fifo_level), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", int'(out_data), i);
      step(0, 8'h00, 1, 1, 0, 0);
    end
    chk("drain_empty", int'(out_valid), 0);

    // Full: drop without pop, then push-with-pop.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 1, 0, 0, 0);
    step(1, 8'h55, 1, 0, 0, 0);
    chk("drop1_cnt", int'(drop_cnt), 1);
    chk("drop1_ovf", int'(overflow), 1);
    chk("drop1_ack", int'(ack_tgl), 0);
    chk("drop1_level", int'(fifo_level), 4);
    chk("drop1_head", int'(out_data), 8'h10);
    step(1, 8'h55, 1, 1, 0, 0);
    chk("pp_level", int'(fifo_level), 4);
    chk("pp_cnt", int'(drop_cnt), 1);
    chk("pp_head", int'(out_data), 8'h11);

    // Saturation at 3 after six drops, then clear beats a same-cycle drop.
    for (int i = 0; i < 5; i++) step(1, 8'h5A, 1, 0, 0, 0);
    chk("sat_cnt", int'(drop_cnt), 3);
    chk("sat_ovf", int'(overflow), 1);
    step(1, 8'h66, 1, 0, 1, 0);
    chk("clr_cnt", int'(drop_cnt), 0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_level", int'(fifo_level), 4);

    // Disabled capture: nothing moves.
    for (int i = 0; i < 3; i++) step(1, 8'h77, 0, 0, 0, 0);
    chk("dis_level", int'(fifo_level), 4);
    chk("dis_ack", int'(ack_tgl), 1);
    chk("dis_cnt", int'(drop_cnt), 0);

    // Reset with two entries held and a pulse in flight.
    step(0, 8'h00, 1, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0, 0);
    chk("pre_rst_level", int'(fifo_level), 2);
    step(1, 8'h88, 1, 0, 0, 1);
    chk_reset_state("midrst");
    step(1, 8'h99, 1, 0, 0, 0);
    chk("post_rst_level", int'(fifo_level), 1);
    chk("post_rst_data", int'(out_data), 8'h99);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
           $urandom_range(0, 199) == 0);
    end
    for (int n = 0; n < 8; n++) step(0, 8'h00, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
